// File: rtl/instr_byte_mem_pkg.sv
// Shared definitions for the instruction byte memory and its program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_byte_mem_pkg;

  localparam int ADDR_W = 19;  // fetch address width from the instruction receiver
  localparam int BYTE_W = 8;   // memory word and stream byte width
  localparam int HDR_W  = 16;  // program byte-count header width

  // Loader FSM: two header bytes (big-endian count), then the data bytes.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } load_state_t;

endpackage

// File: rtl/instr_byte_mem_byte_ram.sv
// Byte-wide storage: one synchronous write port, one asynchronous read port.
// Latency: writes land after the clock edge; reads are combinational.
// Backpressure: none; a write is taken whenever we is high.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module byte_ram
  import instr_byte_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  // No reset: program contents must survive rst.
  logic [BYTE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Same-cycle read of the address being written returns the old byte.
  assign rdata = r_mem[raddr];

endmodule

// File: rtl/instr_byte_mem.sv
// Instruction byte memory with a streaming program loader.
// Latency: fetch is combinational from instr_addr; a load completes one edge after its last accepted byte.
// Backpressure: load_ready is high only while a load is consuming header/data bytes; bytes offered otherwise are ignored.
// Ports: clk, rst (sync, active-high); instr_addr -> instr_1B fetch path;
//        load_start/load_valid/load_byte/load_ready load stream;
//        cpu_hold, load_done, load_overflow status.
module instr_byte_mem
  import instr_byte_mem_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [BYTE_W-1:0] instr_1B,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [BYTE_W-1:0] load_byte,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_overflow
);

  localparam int AW = $clog2(DEPTH);
  // One extra bit so DEPTH = 2^ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  load_state_t       r_state;
  logic [BYTE_W-1:0] r_hdr_hi;
  logic [HDR_W-1:0]  r_wptr;
  logic [HDR_W-1:0]  r_remaining;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_load_overflow;

  logic              w_accept;
  logic              w_wptr_in_range;
  logic              w_rd_in_range;
  logic              w_we;
  logic [HDR_W-1:0]  w_count;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_raddr;
  logic [BYTE_W-1:0] w_rdata;

  assign load_ready = (r_state == ST_HDR_HI) || (r_state == ST_HDR_LO) || (r_state == ST_DATA);
  assign w_accept   = load_valid && load_ready;
  assign w_count    = {r_hdr_hi, load_byte};

  // Pointer is zero-extended, never wrapped, so bytes past DEPTH are dropped.
  assign w_wptr_in_range = {{(ADDR_W + 1 - HDR_W){1'b0}}, r_wptr} < DEPTH_X;
  assign w_rd_in_range   = {1'b0, instr_addr} < DEPTH_X;

  assign w_we    = w_accept && (r_state == ST_DATA) && w_wptr_in_range;
  assign w_waddr = AW'({{(ADDR_W - HDR_W){1'b0}}, r_wptr});
  assign w_raddr = instr_addr[AW-1:0];

  byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_byte_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (load_byte),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // Out-of-range fetches read as zero, which the CPU decodes as halt.
  assign instr_1B = w_rd_in_range ? w_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_hdr_hi        <= '0;
      r_wptr          <= '0;
      r_remaining     <= '0;
      r_cpu_hold      <= 1'b1;
      r_load_done     <= 1'b0;
      r_load_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (load_start) begin
            r_state         <= ST_HDR_HI;
            r_cpu_hold      <= 1'b1;
            r_load_done     <= 1'b0;
            r_load_overflow <= 1'b0;
          end
        end
        ST_HDR_HI: begin
          if (w_accept) begin
            r_hdr_hi <= load_byte;
            r_state  <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (w_accept) begin
            if (w_count == '0) begin
              r_state     <= ST_DONE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
            end else begin
              r_state     <= ST_DATA;
              r_wptr      <= '0;
              r_remaining <= w_count;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            if (!w_wptr_in_range) begin
              r_load_overflow <= 1'b1;
            end
            r_wptr      <= r_wptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == HDR_W'(1)) begin
              r_state     <= ST_DONE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_hold      = r_cpu_hold;
  assign load_done     = r_load_done;
  assign load_overflow = r_load_overflow;

endmodule

// File: tb/tb_instr_byte_mem.sv
// Directed bench for instr_byte_mem: a DEPTH=16 instance and a default-depth
// instance share one load stream; expected values are hand-computed per step.
module tb_instr_byte_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] instr_addr;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;

  logic [7:0]  instr_1B,      big_instr_1B;
  logic        load_ready,    big_load_ready;
  logic        cpu_hold,      big_cpu_hold;
  logic        load_done,     big_load_done;
  logic        load_overflow, big_load_overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] pdata [0:31];

  always #5 clk = ~clk;

  instr_byte_mem #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_1B(instr_1B),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_ready(load_ready), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_overflow(load_overflow)
  );

  instr_byte_mem dut_big (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_1B(big_instr_1B),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_ready(big_load_ready), .cpu_hold(big_cpu_hold), .load_done(big_load_done),
    .load_overflow(big_load_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
    load_byte  = 8'h00;
  endtask

  task automatic do_load(input int n);
    pulse_start();
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_byte(pdata[i]);
  endtask

  task automatic rd(input string tag, input logic [18:0] a, input logic [7:0] exp);
    instr_addr = a;
    #1;
    chk(tag, {24'h0, instr_1B}, {24'h0, exp});
  endtask

  task automatic status(input string tag, input logic hold, input logic rdy,
                        input logic done, input logic ovf);
    chk({tag, ".hold"}, {31'h0, cpu_hold},      {31'h0, hold});
    chk({tag, ".rdy"},  {31'h0, load_ready},    {31'h0, rdy});
    chk({tag, ".done"}, {31'h0, load_done},     {31'h0, done});
    chk({tag, ".ovf"},  {31'h0, load_overflow}, {31'h0, ovf});
  endtask

  initial begin
    rst = 1'b1; instr_addr = '0; load_start = 1'b0; load_valid = 1'b0; load_byte = '0;
    tick(); tick();
    rst = 1'b0;
    status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    // A byte offered while idle must be ignored.
    send_byte(8'hFF);
    status("idle_byte", 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic 4-byte load.
    pdata[0] = 8'h12; pdata[1] = 8'h34; pdata[2] = 8'h56; pdata[3] = 8'h78;
    pulse_start();
    status("hdr_hi", 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h00); send_byte(8'h04);
    for (int i = 0; i < 3; i++) send_byte(pdata[i]);
    status("pre_last", 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(pdata[3]);
    status("load4", 1'b0, 1'b0, 1'b1, 1'b0);
    rd("load4.a0", 19'd0, 8'h12); rd("load4.a1", 19'd1, 8'h34);
    rd("load4.a2", 19'd2, 8'h56); rd("load4.a3", 19'd3, 8'h78);
    chk("load4.big_a3", {24'h0, big_instr_1B}, 32'h78);

    // DONE holds while bytes are offered without load_ready.
    send_byte(8'hEE);
    status("done_byte", 1'b0, 1'b0, 1'b1, 1'b0);
    rd("done_byte.a0", 19'd0, 8'h12);

    // N=0: DONE straight after the HDR_LO accept, memory untouched.
    pulse_start();
    status("n0_start", 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h00); send_byte(8'h00);
    status("n0", 1'b0, 1'b0, 1'b1, 1'b0);
    rd("n0.a0", 19'd0, 8'h12); rd("n0.a3", 19'd3, 8'h78);

    // N=2 over the 4-byte program; check old byte visible on the write cycle.
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    instr_addr = 19'd0;
    load_valid = 1'b1; load_byte = 8'hAA;
    #1;
    chk("rdw_old", {24'h0, instr_1B}, 32'h12);
    tick();
    load_valid = 1'b0;
    chk("rdw_new", {24'h0, instr_1B}, 32'hAA);
    send_byte(8'hBB);
    status("n2", 1'b0, 1'b0, 1'b1, 1'b0);
    rd("n2.a0", 19'd0, 8'hAA); rd("n2.a1", 19'd1, 8'hBB);
    rd("n2.a2", 19'd2, 8'h56); rd("n2.a3", 19'd3, 8'h78);

    // Gaps in load_valid and stray load_start pulses mid-DATA.
    pulse_start();
    send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h11);
    tick();
    pulse_start();
    load_start = 1'b1;
    send_byte(8'h22);
    load_start = 1'b0;
    tick(); tick();
    send_byte(8'h33);
    status("gap_mid", 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h44);
    status("gap", 1'b0, 1'b0, 1'b1, 1'b0);
    rd("gap.a0", 19'd0, 8'h11); rd("gap.a1", 19'd1, 8'h22);
    rd("gap.a2", 19'd2, 8'h33); rd("gap.a3", 19'd3, 8'h44);

    // Reset after 2 of 4 data bytes, then a fresh complete load.
    pulse_start();
    send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h55); send_byte(8'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    status("midrst", 1'b1, 1'b0, 1'b0, 1'b0);
    rd("midrst.a2", 19'd2, 8'h33);
    pdata[0] = 8'h9A; pdata[1] = 8'hBC; pdata[2] = 8'hDE; pdata[3] = 8'hF0;
    do_load(4);
    status("reload", 1'b0, 1'b0, 1'b1, 1'b0);
    rd("reload.a0", 19'd0, 8'h9A); rd("reload.a1", 19'd1, 8'hBC);
    rd("reload.a2", 19'd2, 8'hDE); rd("reload.a3", 19'd3, 8'hF0);

    // N=18 into DEPTH=16: last two bytes dropped, overflow flagged.
    pulse_start();
    send_byte(8'h00); send_byte(8'h12);
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
    status("ovf_16", 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h90);
    status("ovf_17", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("ovf_17.big_ovf", {31'h0, big_load_overflow}, 32'h0);
    send_byte(8'h91);
    status("ovf", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovf.big_done", {31'h0, big_load_done}, 32'h1);
    chk("ovf.big_ovf", {31'h0, big_load_overflow}, 32'h0);
    for (int i = 0; i < 16; i++) rd($sformatf("ovf.a%0d", i), 19'(i), 8'h80 + 8'(i));
    rd("ovf.a16", 19'd16, 8'h00);
    chk("ovf.big_a16", {24'h0, big_instr_1B}, 32'h90);
    rd("ovf.a7ffff", 19'h7FFFF, 8'h00);
    chk("ovf.big_a7ffff", {24'h0, big_instr_1B}, 32'h00);

    // A new load clears the overflow flag.
    pulse_start();
    status("ovf_clear", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Backstop so a broken design cannot keep the run alive.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_byte_mem.md
INSTR_BYTE_MEM -- requirements
Module: instr_byte_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, instruction memory size in bytes (power of two, 16..524288).
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: instr_addr  in  19  fetch byte address from the instruction receiver.
REQ-005 SHALL have port: instr_1B  out  8  fetched byte.
REQ-006 SHALL have port: load_start  in  1  begin a program load.
REQ-007 SHALL have port: load_valid  in  1  load_byte is valid.
REQ-008 SHALL have port: load_byte  in  8  program stream byte.
REQ-009 SHALL have port: load_ready  out  1  block accepts load_byte this cycle.
REQ-010 SHALL have port: cpu_hold  out  1  receiver must not fetch while high.
REQ-011 SHALL have port: load_done  out  1  last load completed.
REQ-012 SHALL have port: load_overflow  out  1  last load exceeded DEPTH.

Function
REQ-013 instr_1B SHALL be combinational from instr_addr: mem[instr_addr] when instr_addr < DEPTH, else 8'h00, so out-of-range fetches read as halt (all-zero word).
REQ-014 FSM states SHALL be IDLE, HDR_HI, HDR_LO, DATA, DONE.
REQ-015 load_ready SHALL be 1 exactly in HDR_HI, HDR_LO, DATA; a byte is accepted on an edge with load_valid && load_ready.
REQ-016 load_start in IDLE or DONE SHALL go to HDR_HI, set cpu_hold=1, clear load_done and load_overflow; load_start in HDR_HI/HDR_LO/DATA SHALL be ignored.
REQ-017 Stream format: byte count N (16-bit, big-endian: HDR_HI then HDR_LO), then N program bytes written at addresses 0..N-1 in arrival order.
REQ-018 Accept in HDR_LO SHALL go to DONE if N==0, else DATA with write pointer 0 and remaining=N.
REQ-019 Each DATA accept SHALL write mem[wptr] if wptr < DEPTH, else discard the byte and set load_overflow; wptr increments, remaining decrements.
REQ-020 The DATA accept with remaining==1 SHALL go to DONE on the same edge.
REQ-021 Entering DONE SHALL set load_done=1 and cpu_hold=0 on that edge; DONE holds until load_start or rst.
REQ-022 Bytes with load_valid while load_ready=0 SHALL be ignored, with no state change.
REQ-023 A write takes effect after the edge; a same-cycle read of the written address returns the old byte.
REQ-024 Bytes above N-1 SHALL keep prior contents; a load never clears memory.
REQ-025 Write pointer and remaining SHALL be 16-bit counters; addresses are zero-extended to 19 bits for the DEPTH compare, with no wrap.

Reset
REQ-026 rst SHALL force IDLE, cpu_hold=1, load_done=0, load_overflow=0, load_ready=0, and counters to 0 on the next edge, including mid-load.
REQ-027 Memory contents SHALL NOT be reset; cpu_hold stays 1 after reset until a load completes.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, ADDR_W=19, BYTE_W=8, and the header width (16).
REQ-029 Storage SHALL be one sub-module, byte_ram: one synchronous write port and one asynchronous read port, depth DEPTH.

Verification
REQ-030 Reset, then load N=4 bytes 12 34 56 78 -> load_done=1, cpu_hold=0 one edge after the 4th accept; instr_addr 0..3 reads 12,34,56,78.
REQ-031 Load N=0 -> DONE right after the HDR_LO accept, no writes, load_overflow=0, previous contents intact.
REQ-032 DEPTH=16, N=18 -> addresses 0..15 written, last 2 bytes dropped, load_overflow=1, load_done=1; instr_addr=16 reads 00.
REQ-033 Gaps in load_valid plus load_start pulses mid-DATA -> the byte sequence is unchanged and the extra load_start is ignored.
REQ-034 rst asserted after 2 of 4 data bytes -> IDLE, cpu_hold=1, load_ready=0; a new full load then completes correctly.
REQ-035 A second load with N=2 (AA BB) over a prior 4-byte program -> reads give AA, BB, 56, 78.
